// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory port seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic        instr_req_ip;
    logic [31:0] instr_addr_ip;
    logic        instr_gnt_op;
    logic        instr_rvalid_op;
    logic [31:0] instr_rdata_op;

    logic        data_req_ip;
    logic        data_we_ip;
    logic [3:0]  data_be_ip;
    logic [31:0] data_addr_ip;
    logic [31:0] data_wdata_ip;
    logic        data_gnt_op;
    logic        data_rvalid_op;
    logic [31:0] data_rdata_op;

    logic        mem_req_op;
    logic        mem_we_op;
    logic [3:0]  mem_be_op;
    logic [31:0] mem_addr_op;
    logic [31:0] mem_wdata_op;
    logic        mem_gnt_ip;
    logic        mem_rvalid_ip;
    logic [31:0] mem_rdata_ip;

    logic        timeout_err_op;

    modport slave (
        input  instr_req_ip, instr_addr_ip,
        input  data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
        input  mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
        output instr_gnt_op, instr_rvalid_op, instr_rdata_op,
        output data_gnt_op, data_rvalid_op, data_rdata_op,
        output mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        output timeout_err_op
    );

    modport master (
        output instr_req_ip, instr_addr_ip,
        output data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
        output mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
        input  instr_gnt_op, instr_rvalid_op, instr_rdata_op,
        input  data_gnt_op, data_rvalid_op, data_rdata_op,
        input  mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
        input  timeout_err_op
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-source (fetch / load-store) arbiter onto a single memory port, one transaction
// outstanding, data-priority with bounded instruction starvation and a wait timeout.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    state_t   state_q, state_d;
    mem_cmd_t cmd_q, cmd_d;
    logic     mem_req_q, mem_req_d;
    logic     owner_instr_q, owner_instr_d;
    logic     err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic     sel_instr_c;

    // Fetch wins only when data is absent or the starvation budget is spent.
    assign sel_instr_c = bus.instr_req_ip &&
                         (!bus.data_req_ip || (starve_q == SW'(STARVE_LIMIT)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            mem_req_q     <= 1'b0;
            owner_instr_q <= 1'b0;
            err_q         <= 1'b0;
            starve_q      <= '0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            mem_req_q     <= mem_req_d;
            owner_instr_q <= owner_instr_d;
            err_q         <= err_d;
            starve_q      <= starve_d;
            wait_q        <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        mem_req_d     = 1'b0;
        owner_instr_d = owner_instr_q;
        err_d         = err_q;
        starve_d      = starve_q;
        wait_d        = wait_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_req_ip || bus.data_req_ip) begin
                    state_d       = REQ;
                    mem_req_d     = 1'b1;
                    wait_d        = '0;
                    owner_instr_d = sel_instr_c;
                    if (sel_instr_c) begin
                        cmd_d    = '{we: 1'b0, be: 4'hF, addr: bus.instr_addr_ip, wdata: 32'h0};
                        starve_d = '0;
                    end else begin
                        cmd_d = '{we: bus.data_we_ip, be: bus.data_be_ip,
                                  addr: bus.data_addr_ip, wdata: bus.data_wdata_ip};
                        if (bus.instr_req_ip && (starve_q != SW'(STARVE_LIMIT)))
                            starve_d = starve_q + SW'(1);
                    end
                end
            end
            REQ: begin
                mem_req_d = 1'b1;
                if (bus.mem_gnt_ip) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    wait_d    = '0;
                end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            RESP: begin
                if (bus.mem_rvalid_ip) begin
                    state_d = IDLE;
                end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant and response strobes follow the memory handshake in the same cycle.
    assign bus.instr_gnt_op    = (state_q == REQ) && bus.mem_gnt_ip && owner_instr_q;
    assign bus.data_gnt_op     = (state_q == REQ) && bus.mem_gnt_ip && !owner_instr_q;
    assign bus.instr_rvalid_op = (state_q == RESP) && bus.mem_rvalid_ip && owner_instr_q;
    assign bus.data_rvalid_op  = (state_q == RESP) && bus.mem_rvalid_ip && !owner_instr_q;
    assign bus.instr_rdata_op  = bus.instr_rvalid_op ? bus.mem_rdata_ip : 32'h0;
    assign bus.data_rdata_op   = bus.data_rvalid_op ? bus.mem_rdata_ip : 32'h0;

    assign bus.mem_req_op     = mem_req_q;
    assign bus.mem_we_op      = cmd_q.we;
    assign bus.mem_be_op      = cmd_q.be;
    assign bus.mem_addr_op    = cmd_q.addr;
    assign bus.mem_wdata_op   = cmd_q.wdata;
    assign bus.timeout_err_op = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level model
// of the arbitration rule, memory handshake, timeout and reset behaviour.
module tb_mem_arbiter;
    localparam int unsigned STARVE  = 4;
    localparam int unsigned TIMEOUT = 255;

    logic clock;
    logic reset;
    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int streak = 0;      // consecutive data wins while a fetch was waiting
    bit exp_err = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":mem_req"},     32'(bus.mem_req_op), 0);
        check({tag, ":mem_we"},      32'(bus.mem_we_op), 0);
        check({tag, ":mem_be"},      32'(bus.mem_be_op), 0);
        check({tag, ":mem_addr"},    bus.mem_addr_op, 0);
        check({tag, ":mem_wdata"},   bus.mem_wdata_op, 0);
        check({tag, ":i_gnt"},       32'(bus.instr_gnt_op), 0);
        check({tag, ":i_rvalid"},    32'(bus.instr_rvalid_op), 0);
        check({tag, ":i_rdata"},     bus.instr_rdata_op, 0);
        check({tag, ":d_gnt"},       32'(bus.data_gnt_op), 0);
        check({tag, ":d_rvalid"},    32'(bus.data_rvalid_op), 0);
        check({tag, ":d_rdata"},     bus.data_rdata_op, 0);
        check({tag, ":timeout_err"}, 32'(bus.timeout_err_op), 0);
    endtask

    // One full transaction: requests are presented while the arbiter is idle, memory
    // grants after g stall cycles and responds after r stall cycles.
    task automatic txn(input string tag, input bit iq, input bit dq, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] dw, input bit we,
                       input logic [3:0] be, input int g, input int r, input logic [31:0] rd);
        bit win_i;
        logic [31:0] exp_addr;
        win_i = iq && (!dq || streak >= int'(STARVE));
        if (win_i) streak = 0;
        else if (iq && streak < int'(STARVE)) streak++;
        exp_addr = win_i ? ia : da;

        bus.instr_req_ip = iq;   bus.instr_addr_ip = ia;
        bus.data_req_ip  = dq;   bus.data_addr_ip  = da;
        bus.data_wdata_ip = dw;  bus.data_we_ip    = we;  bus.data_be_ip = be;
        @(posedge clock); #1;
        // Source fields change while the request is in flight and must be ignored.
        bus.instr_addr_ip = $urandom;
        bus.data_addr_ip  = $urandom;
        bus.data_wdata_ip = $urandom;
        check({tag, ":mem_req"},  32'(bus.mem_req_op), 1);
        check({tag, ":mem_addr"}, bus.mem_addr_op, exp_addr);
        check({tag, ":mem_we"},   32'(bus.mem_we_op), win_i ? 0 : 32'(we));
        if (!win_i) begin
            check({tag, ":mem_be"},    32'(bus.mem_be_op), 32'(be));
            check({tag, ":mem_wdata"}, bus.mem_wdata_op, dw);
        end
        repeat (g) begin
            check({tag, ":early_gnt"}, 32'({bus.instr_gnt_op, bus.data_gnt_op}), 0);
            @(posedge clock); #1;
            check({tag, ":held_req"},  32'(bus.mem_req_op), 1);
            check({tag, ":held_addr"}, bus.mem_addr_op, exp_addr);
        end
        bus.mem_gnt_ip = 1'b1;
        #1;
        check({tag, ":i_gnt"}, 32'(bus.instr_gnt_op), 32'(win_i));
        check({tag, ":d_gnt"}, 32'(bus.data_gnt_op), 32'(!win_i));
        @(posedge clock); #1;
        bus.mem_gnt_ip = 1'b0;
        check({tag, ":resp_req"}, 32'(bus.mem_req_op), 0);
        check({tag, ":gnt_pulse"}, 32'({bus.instr_gnt_op, bus.data_gnt_op}), 0);
        repeat (r) begin
            check({tag, ":early_rv"}, 32'({bus.instr_rvalid_op, bus.data_rvalid_op}), 0);
            @(posedge clock); #1;
        end
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = rd;
        #1;
        check({tag, ":i_rvalid"}, 32'(bus.instr_rvalid_op), 32'(win_i));
        check({tag, ":d_rvalid"}, 32'(bus.data_rvalid_op), 32'(!win_i));
        if (win_i) begin
            check({tag, ":i_rdata"}, bus.instr_rdata_op, rd);
            check({tag, ":d_rdata"}, bus.data_rdata_op, 0);
        end else if (!we) begin
            check({tag, ":d_rdata"}, bus.data_rdata_op, rd);
            check({tag, ":i_rdata"}, bus.instr_rdata_op, 0);
        end
        @(posedge clock); #1;
        bus.mem_rvalid_ip = 1'b0;
        bus.mem_rdata_ip  = 32'h0;
        check({tag, ":timeout_err"}, 32'(bus.timeout_err_op), 32'(exp_err));
    endtask

    initial begin
        int  cnt;
        bit  saw_gnt;
        bit  done;
        bit  iq, dq;

        reset = 1'b0;
        bus.instr_req_ip = 1'b0; bus.instr_addr_ip = 32'h0;
        bus.data_req_ip  = 1'b0; bus.data_we_ip = 1'b0; bus.data_be_ip = 4'h0;
        bus.data_addr_ip = 32'h0; bus.data_wdata_ip = 32'h0;
        bus.mem_gnt_ip   = 1'b0; bus.mem_rvalid_ip = 1'b0; bus.mem_rdata_ip = 32'h0;
        #2;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Fetch only, immediate memory handshake.
        txn("fetch", 1, 0, 32'h10, 32'h0, 32'h0, 0, 4'h0, 0, 0, 32'h0050_0093);

        // Both request together: store first, the fetch stays pending and follows.
        txn("both_st", 1, 1, 32'h44, 32'h80, 32'hDEAD_BEEF, 1, 4'hF, 0, 0, 32'h0);
        txn("both_if", 1, 0, 32'h44, 32'h0, 32'h0, 0, 4'h0, 0, 0, 32'h1234_5678);

        // Continuous contention: 4 data wins then 1 fetch, twice.
        for (int i = 0; i < 10; i++)
            txn($sformatf("starve%0d", i), 1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i),
                $urandom, 1'($urandom), 4'($urandom), 0, 1, $urandom);

        // Randomized mix of sources, fields and memory stall lengths.
        for (int i = 0; i < 40; i++) begin
            iq = 1'($urandom);
            dq = 1'($urandom);
            if (!iq && !dq) dq = 1'b1;
            txn($sformatf("rnd%0d", i), iq, dq, $urandom, $urandom, $urandom,
                1'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom);
        end

        // Memory never grants: the request is aborted after the timeout.
        bus.instr_req_ip = 1'b1; bus.instr_addr_ip = 32'h200; bus.data_req_ip = 1'b0;
        streak = 0;
        cnt = 0; saw_gnt = 1'b0; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clock); #1;
            if (bus.instr_gnt_op || bus.data_gnt_op) saw_gnt = 1'b1;
            if (bus.mem_req_op) cnt++;
            else done = 1'b1;
        end
        bus.instr_req_ip = 1'b0;
        check("to:finished",   32'(done), 1);
        check("to:req_cycles", 32'(cnt), TIMEOUT);
        check("to:no_gnt",     32'(saw_gnt), 0);
        check("to:flag",       32'(bus.timeout_err_op), 1);
        exp_err = 1'b1;
        @(posedge clock); #1;
        check("to:idle", 32'(bus.mem_req_op), 0);
        txn("after_to", 0, 1, 32'h0, 32'h300, 32'h0, 0, 4'h3, 1, 1, 32'hA5A5_5A5A);

        // Reset while waiting for the response: nothing may be delivered after release.
        bus.data_req_ip = 1'b0; bus.instr_req_ip = 1'b1; bus.instr_addr_ip = 32'h300;
        @(posedge clock); #1;
        bus.mem_gnt_ip = 1'b1;
        @(posedge clock); #1;
        bus.mem_gnt_ip = 1'b0;
        bus.instr_req_ip = 1'b0;
        #1 reset = 1'b0;
        #1 check_zero("rst_resp");
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'hCAFE_F00D;
        #1 check_zero("rst_rv");
        @(negedge clock);
        reset = 1'b1;
        exp_err = 1'b0;
        streak = 0;
        repeat (3) begin
            @(posedge clock); #1;
            check("rel:i_rvalid", 32'(bus.instr_rvalid_op), 0);
            check("rel:d_rvalid", 32'(bus.data_rvalid_op), 0);
            check("rel:mem_req",  32'(bus.mem_req_op), 0);
            check("rel:err",      32'(bus.timeout_err_op), 0);
        end
        bus.mem_rvalid_ip = 1'b0;
        bus.mem_rdata_ip  = 32'h0;

        // Selection on the very first edge after reset release.
        #1 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        txn("post_rst", 1, 1, 32'h400, 32'h500, 32'h0BAD_F00D, 0, 4'hF, 0, 0, 32'h7777_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
